// File: rtl/parking_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | parking_ctrl: speed-trap and barrier control FSMs feeding the datapath.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module parking_ctrl #(
    parameter int SYS_FREQ   = 50000000,
    parameter int WIDTH_MS   = 10,
    parameter int TIMEOUT_MS = 1000,
    parameter int MAX_VEH    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sen_a,
    input  logic       sen_b,
    input  logic       sen_in,
    input  logic       sen_out,
    input  logic       sen_pass,
    input  logic [1:0] num_veh,
    input  logic       done,
    output logic       init,
    output logic       count,
    output logic       cal,
    output logic       up,
    output logic       down,
    output logic       en,
    output logic       dis,
    output logic       speed_valid,
    output logic       timeout,
    output logic       overspeed,
    output logic       full
);

    localparam int TICKS_PER_MS = SYS_FREQ / 1000;
    localparam int TICK_W       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICKS_PER_MS - 1);
    localparam logic [WIDTH_MS-1:0] MS_LIMIT  = WIDTH_MS'(TIMEOUT_MS);
    localparam logic [1:0]          VEH_LIMIT = 2'(MAX_VEH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_CAL   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [0:0] B_IDLE  = 1'b0;
    localparam logic [0:0] B_OPEN  = 1'b1;

    // Sensor order in the vectors: {pass, out, in, b, a}
    logic [4:0] w_sens;
    logic [4:0] r_sync1, r_sync2, r_prev, r_rise;
    logic       w_a_rise, w_b_rise, w_in_rise, w_out_rise, w_pass_rise;

    logic [2:0]          r_spd_state, w_spd_next;
    logic [0:0]          r_bar_state, w_bar_next;
    logic [TICK_W-1:0]   r_tick;
    logic [WIDTH_MS-1:0] r_ms;
    logic                r_full;
    logic                w_ms_limit, w_exit_ok, w_entry_ok;

    assign w_sens      = {sen_pass, sen_out, sen_in, sen_b, sen_a};
    assign w_a_rise    = r_rise[0];
    assign w_b_rise    = r_rise[1];
    assign w_in_rise   = r_rise[2];
    assign w_out_rise  = r_rise[3];
    assign w_pass_rise = r_rise[4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_rise  <= '0;
        end else begin
            r_sync1 <= w_sens;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    // ---------------- speed FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_spd_state <= S_IDLE;
        else          r_spd_state <= w_spd_next;
    end

    assign w_ms_limit = (r_ms == MS_LIMIT);

    always_comb begin
        w_spd_next = r_spd_state;
        case (r_spd_state)
            S_IDLE:  if (w_a_rise) w_spd_next = S_INIT;
            S_INIT:  w_spd_next = S_COUNT;
            S_COUNT: begin
                if (w_ms_limit)    w_spd_next = S_IDLE;
                else if (w_b_rise) w_spd_next = (r_ms == '0) ? S_IDLE : S_CAL;
            end
            S_CAL:   w_spd_next = S_WAIT;
            S_WAIT:  if (done) w_spd_next = S_IDLE;
            default: w_spd_next = S_IDLE;
        endcase
    end

    always_comb begin
        init        = 1'b0;
        count       = 1'b0;
        cal         = 1'b0;
        speed_valid = 1'b0;
        timeout     = 1'b0;
        overspeed   = 1'b0;
        case (r_spd_state)
            S_INIT:  init = 1'b1;
            S_COUNT: begin
                count     = 1'b1;
                timeout   = w_ms_limit;
                overspeed = !w_ms_limit && w_b_rise && (r_ms == '0);
            end
            S_CAL:   cal = 1'b1;
            S_WAIT:  speed_valid = done;
            default: ;
        endcase
    end

    // Elapsed-time base mirrors the datapath's ms counter so the ms==0 guard agrees with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick <= '0;
            r_ms   <= '0;
        end else if (r_spd_state == S_INIT) begin
            r_tick <= '0;
            r_ms   <= '0;
        end else if (r_spd_state == S_COUNT) begin
            if (r_tick == TICK_LAST) begin
                r_tick <= '0;
                r_ms   <= r_ms + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    // ---------------- barrier FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bar_state <= B_IDLE;
            r_full      <= 1'b0;
        end else begin
            r_bar_state <= w_bar_next;
            r_full      <= (num_veh >= VEH_LIMIT);
        end
    end

    assign w_exit_ok  = w_out_rise && (num_veh != 2'd0);
    assign w_entry_ok = !w_exit_ok && w_in_rise && !r_full;

    always_comb begin
        w_bar_next = r_bar_state;
        case (r_bar_state)
            B_IDLE:  if (w_exit_ok || w_entry_ok) w_bar_next = B_OPEN;
            B_OPEN:  if (w_pass_rise) w_bar_next = B_IDLE;
            default: w_bar_next = B_IDLE;
        endcase
    end

    always_comb begin
        up   = 1'b0;
        down = 1'b0;
        en   = 1'b0;
        dis  = 1'b0;
        case (r_bar_state)
            B_IDLE: begin
                down = w_exit_ok;
                en   = w_exit_ok;
                up   = w_entry_ok;
            end
            B_OPEN:  dis = w_pass_rise;
            default: ;
        endcase
    end

    assign full = r_full;

endmodule
`default_nettype wire

// File: tb/tb_parking_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_parking_ctrl: bench for parking_ctrl with a small datapath stand-in.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_parking_ctrl;

    localparam int SYS_FREQ = 100000;
    localparam int TPM      = SYS_FREQ / 1000;

    localparam int C_INIT = 0, C_COUNT = 1, C_CAL = 2, C_UP = 3, C_DOWN = 4, C_EN = 5;
    localparam int C_DIS = 6, C_SV = 7, C_TO = 8, C_OS = 9, C_TCAL = 10, C_TTO = 11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sen_a = 1'b0, sen_b = 1'b0, sen_in = 1'b0, sen_out = 1'b0, sen_pass = 1'b0;
    logic [1:0] num_veh;
    logic done;
    logic init, count, cal, up, down, en, dis, speed_valid, timeout, overspeed, full;
    logic t_init, t_count, t_cal, t_up, t_down, t_en, t_dis, t_sv, t_timeout, t_os, t_full;
    logic [10:0] outs, outs_t;

    assign outs   = {init, count, cal, up, down, en, dis, speed_valid, timeout, overspeed, full};
    assign outs_t = {t_init, t_count, t_cal, t_up, t_down, t_en, t_dis, t_sv, t_timeout, t_os, t_full};

    always #5 clk = ~clk;

    parking_ctrl #(.SYS_FREQ(SYS_FREQ), .WIDTH_MS(10), .TIMEOUT_MS(30), .MAX_VEH(3)) dut (
        .clk(clk), .reset_n(reset_n), .sen_a(sen_a), .sen_b(sen_b), .sen_in(sen_in),
        .sen_out(sen_out), .sen_pass(sen_pass), .num_veh(num_veh), .done(done),
        .init(init), .count(count), .cal(cal), .up(up), .down(down), .en(en), .dis(dis),
        .speed_valid(speed_valid), .timeout(timeout), .overspeed(overspeed), .full(full)
    );

    // Short-timeout instance used only for the abort scenario
    parking_ctrl #(.SYS_FREQ(SYS_FREQ), .WIDTH_MS(10), .TIMEOUT_MS(5), .MAX_VEH(3)) dut_t (
        .clk(clk), .reset_n(reset_n), .sen_a(sen_a), .sen_b(1'b0), .sen_in(1'b0),
        .sen_out(1'b0), .sen_pass(1'b0), .num_veh(2'b00), .done(1'b0),
        .init(t_init), .count(t_count), .cal(t_cal), .up(t_up), .down(t_down), .en(t_en),
        .dis(t_dis), .speed_valid(t_sv), .timeout(t_timeout), .overspeed(t_os), .full(t_full)
    );

    // Datapath stand-in: occupancy counter, ms timer rounded to nearest ms, slow divider
    int cc, dly, spd;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_veh <= 2'd0;
            done    <= 1'b0;
            cc      <= 0;
            dly     <= 0;
            spd     <= 0;
        end else begin
            if (up)        num_veh <= num_veh + 2'd1;
            else if (down) num_veh <= num_veh - 2'd1;
            if (init)       cc <= 0;
            else if (count) cc <= cc + 1;
            if (cal) begin
                spd <= (((cc + 50) / TPM) == 0) ? 0 : 14400 / ((cc + 50) / TPM);
                dly <= 3;
            end else if (dly != 0) begin
                dly <= dly - 1;
            end
            done <= (dly == 1);
        end
    end

    int cnt [0:11] = '{default: 0};
    int cyc = 0, t_start = 0, t_to_cyc = 0, last_speed = 0, viol = 0;
    logic t_count_q = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (init)        cnt[C_INIT]  <= cnt[C_INIT] + 1;
        if (count)       cnt[C_COUNT] <= cnt[C_COUNT] + 1;
        if (cal)         cnt[C_CAL]   <= cnt[C_CAL] + 1;
        if (up)          cnt[C_UP]    <= cnt[C_UP] + 1;
        if (down)        cnt[C_DOWN]  <= cnt[C_DOWN] + 1;
        if (en)          cnt[C_EN]    <= cnt[C_EN] + 1;
        if (dis)         cnt[C_DIS]   <= cnt[C_DIS] + 1;
        if (timeout)     cnt[C_TO]    <= cnt[C_TO] + 1;
        if (overspeed)   cnt[C_OS]    <= cnt[C_OS] + 1;
        if (t_cal)       cnt[C_TCAL]  <= cnt[C_TCAL] + 1;
        if (speed_valid) begin
            cnt[C_SV]  <= cnt[C_SV] + 1;
            last_speed <= spd;
        end
        if (t_timeout) begin
            cnt[C_TTO] <= cnt[C_TTO] + 1;
            t_to_cyc   <= cyc;
        end
        if (t_count && !t_count_q) t_start <= cyc;
        t_count_q <= t_count;
        if ((up && down) || !$onehot0({init, count, cal}) || !$onehot0({up, down, dis}) || (en != down))
            viol <= viol + 1;
    end

    int n_total = 0, n_pass = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endfunction

    function automatic void chk_rng(input string nm, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_bar(input logic i, input logic o, input logic p);
        sen_in = i; sen_out = o; sen_pass = p;
        repeat (4) tick();
        sen_in = 1'b0; sen_out = 1'b0; sen_pass = 1'b0;
        repeat (6) tick();
    endtask

    task automatic speed_run(input int gap);
        sen_a = 1'b1;
        for (int c = 1; c <= gap; c++) begin
            tick();
            if (c == 4) sen_a = 1'b0;
        end
        sen_b = 1'b1;
        repeat (4) tick();
        sen_b = 1'b0;
        repeat (20) tick();
    endtask

    typedef struct {
        string name;
        bit    i, o, p;
        int    e_up, e_down, e_dis, e_nv, e_full;
    } vec_t;

    vec_t tbl [17];
    int   s [0:11];
    int   occ, k, gap, r, e_up, e_down, e_dis, d;
    bit   open_g, ri, ro, rp;

    initial begin
        tbl[0]  = '{"entry1",            1, 0, 0, 1, 0, 0, 1, 0};
        tbl[1]  = '{"pass1",             0, 0, 1, 0, 0, 1, 1, 0};
        tbl[2]  = '{"entry2",            1, 0, 0, 1, 0, 0, 2, 0};
        tbl[3]  = '{"pass2",             0, 0, 1, 0, 0, 1, 2, 0};
        tbl[4]  = '{"entry3",            1, 0, 0, 1, 0, 0, 3, 1};
        tbl[5]  = '{"pass3",             0, 0, 1, 0, 0, 1, 3, 1};
        tbl[6]  = '{"entry_full",        1, 0, 0, 0, 0, 0, 3, 1};
        tbl[7]  = '{"exit_from_full",    0, 1, 0, 0, 1, 0, 2, 0};
        tbl[8]  = '{"entry_while_open",  1, 0, 0, 0, 0, 0, 2, 0};
        tbl[9]  = '{"pass4",             0, 0, 1, 0, 0, 1, 2, 0};
        tbl[10] = '{"simul_in_out",      1, 1, 0, 0, 1, 0, 1, 0};
        tbl[11] = '{"entry_while_open2", 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[12] = '{"pass5",             0, 0, 1, 0, 0, 1, 1, 0};
        tbl[13] = '{"exit_last",         0, 1, 0, 0, 1, 0, 0, 0};
        tbl[14] = '{"pass6",             0, 0, 1, 0, 0, 1, 0, 0};
        tbl[15] = '{"exit_empty",        0, 1, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{"pass_idle",         0, 0, 1, 0, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(outs), 0);
        chk("reset_outputs_t", int'(outs_t), 0);
        reset_n = 1'b1;
        repeat (5) tick();

        // Barrier scenarios from the table
        foreach (tbl[j]) begin
            s = cnt;
            pulse_bar(tbl[j].i, tbl[j].o, tbl[j].p);
            chk({tbl[j].name, " up"},   cnt[C_UP]   - s[C_UP],   tbl[j].e_up);
            chk({tbl[j].name, " down"}, cnt[C_DOWN] - s[C_DOWN], tbl[j].e_down);
            chk({tbl[j].name, " en"},   cnt[C_EN]   - s[C_EN],   tbl[j].e_down);
            chk({tbl[j].name, " dis"},  cnt[C_DIS]  - s[C_DIS],  tbl[j].e_dis);
            chk({tbl[j].name, " num_veh"}, int'(num_veh), tbl[j].e_nv);
            chk({tbl[j].name, " full"}, int'(full), tbl[j].e_full);
        end

        // Speed OK: 1500 clk between loops -> 15 ms -> 960 km/h
        s = cnt;
        speed_run(1500);
        chk("ok init",  cnt[C_INIT]  - s[C_INIT],  1);
        chk("ok count", cnt[C_COUNT] - s[C_COUNT], 1499);
        chk("ok cal",   cnt[C_CAL]   - s[C_CAL],   1);
        chk("ok speed_valid", cnt[C_SV] - s[C_SV], 1);
        chk("ok overspeed", cnt[C_OS] - s[C_OS], 0);
        chk("ok speed", last_speed, 960);

        // Overspeed: sen_b 50 clk after sen_a
        s = cnt;
        speed_run(50);
        chk("os overspeed", cnt[C_OS] - s[C_OS], 1);
        chk("os cal", cnt[C_CAL] - s[C_CAL], 0);
        chk("os speed_valid", cnt[C_SV] - s[C_SV], 0);
        chk("os count", cnt[C_COUNT] - s[C_COUNT], 49);

        // Random barrier traffic against an occupancy/gate model
        occ = 0;
        open_g = 1'b0;
        for (int n = 0; n < 30; n++) begin
            r  = $urandom_range(0, 3);
            ri = (r == 0) || (r == 3);
            ro = (r == 1) || (r == 3);
            rp = (r == 2);
            e_up = 0; e_down = 0; e_dis = 0;
            if (!open_g) begin
                if (ro && occ > 0) begin
                    occ--; e_down = 1; open_g = 1'b1;
                end else if (ri && occ < 3) begin
                    occ++; e_up = 1; open_g = 1'b1;
                end
            end else if (rp) begin
                e_dis = 1; open_g = 1'b0;
            end
            s = cnt;
            pulse_bar(ri, ro, rp);
            chk($sformatf("rnd%0d up", n),   cnt[C_UP]   - s[C_UP],   e_up);
            chk($sformatf("rnd%0d down", n), cnt[C_DOWN] - s[C_DOWN], e_down);
            chk($sformatf("rnd%0d dis", n),  cnt[C_DIS]  - s[C_DIS],  e_dis);
            chk($sformatf("rnd%0d num_veh", n), int'(num_veh), occ);
        end

        // Random speed measurements; gaps sit mid-millisecond so k ms elapse
        for (int n = 0; n < 10; n++) begin
            k   = $urandom_range(0, 15);
            gap = 100 * k + 50;
            s = cnt;
            speed_run(gap);
            chk($sformatf("spd%0d init", n),  cnt[C_INIT] - s[C_INIT], 1);
            chk($sformatf("spd%0d count", n), cnt[C_COUNT] - s[C_COUNT], gap - 1);
            chk($sformatf("spd%0d cal", n),   cnt[C_CAL] - s[C_CAL], (k > 0) ? 1 : 0);
            chk($sformatf("spd%0d valid", n), cnt[C_SV] - s[C_SV], (k > 0) ? 1 : 0);
            chk($sformatf("spd%0d overspeed", n), cnt[C_OS] - s[C_OS], (k == 0) ? 1 : 0);
            chk($sformatf("spd%0d timeout", n), cnt[C_TO] - s[C_TO], 0);
            if (k > 0) chk($sformatf("spd%0d speed k=%0d", n, k), last_speed, 14400 / k);
        end

        // Timeout on the 5 ms instance
        repeat (600) tick();
        s = cnt;
        sen_a = 1'b1;
        repeat (4) tick();
        sen_a = 1'b0;
        for (int c = 0; c < 800 && cnt[C_TTO] == s[C_TTO]; c++) tick();
        chk("to pulse", cnt[C_TTO] - s[C_TTO], 1);
        d = t_to_cyc - t_start;
        chk_rng("to latency", d, 498, 502);
        repeat (3) tick();
        chk("to back_idle", int'(t_count), 0);
        chk("to no_cal", cnt[C_TCAL] - s[C_TCAL], 0);

        // Main instance is now mid-COUNT; bring the gate to B_OPEN as well
        if (open_g) begin
            pulse_bar(1'b0, 1'b0, 1'b1);
            open_g = 1'b0;
        end
        if (occ == 3) begin
            pulse_bar(1'b0, 1'b1, 1'b0);
            pulse_bar(1'b0, 1'b0, 1'b1);
        end
        s = cnt;
        pulse_bar(1'b1, 1'b0, 1'b0);
        chk("pre_reset up", cnt[C_UP] - s[C_UP], 1);
        chk("pre_reset in_count", int'(count), 1);

        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset outputs", int'(outs), 0);
        chk("async_reset outputs_t", int'(outs_t), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        s = cnt;
        repeat (30) tick();
        d = 0;
        for (int j = C_INIT; j <= C_OS; j++) d += cnt[j] - s[j];
        chk("post_reset no_strobes", d, 0);

        s = cnt;
        pulse_bar(1'b1, 1'b0, 1'b0);
        chk("post_reset entry up", cnt[C_UP] - s[C_UP], 1);
        chk("post_reset num_veh", int'(num_veh), 1);
        s = cnt;
        speed_run(250);
        chk("post_reset init", cnt[C_INIT] - s[C_INIT], 1);
        chk("post_reset speed_valid", cnt[C_SV] - s[C_SV], 1);
        chk("post_reset speed", last_speed, 7200);

        chk("strobe_rule_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
